// File: rtl/debounce_edge_if.sv
// Purpose : signal bundle between a debounce_edge instance and its user.
// Signals : d          - synchronized raw inputs (driven by master)
//           q          - debounced levels
//           rise/fall  - one-cycle pulses on accepted 0->1 / 1->0 changes
//           glitch_cnt - rejected-bounce counter, only with DEBOUNCE_EDGE_STATS_EN
// Modports: master (input source / output consumer), slave (the debouncer).
interface debounce_edge_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
`ifdef DEBOUNCE_EDGE_STATS_EN
  logic [15:0]      glitch_cnt;

  modport master (output d, input q, rise, fall, glitch_cnt);
  modport slave  (input d, output q, rise, fall, glitch_cnt);
`else
  modport master (output d, input q, rise, fall);
  modport slave  (input d, output q, rise, fall);
`endif
endinterface

// File: rtl/debounce_edge.sv
// Purpose : per-bit debouncer and edge detector for slow, already-synchronized
//           inputs. A channel's level q changes only after d has differed from
//           it for STABLE_CYCLES consecutive clocks; each accepted change emits
//           a one-cycle rise or fall pulse. All outputs are registered.
// Ports   : clk - clock
//           rst - asynchronous, active-high reset
//           bus - debounce_edge_if.slave (d in; q, rise, fall out;
//                 glitch_cnt out when DEBOUNCE_EDGE_STATS_EN is defined)
// Options : DEBOUNCE_EDGE_STATS_EN adds a saturating 16-bit count of edges on
//           which at least one channel abandoned a partial count.
module debounce_edge #(
  parameter int unsigned WIDTH         = 1,
  parameter int unsigned STABLE_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           rst,
  debounce_edge_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0]            level_q, level_d;
  logic [WIDTH-1:0]            rise_q,  rise_d;
  logic [WIDTH-1:0]            fall_q,  fall_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q,   cnt_d;

  // Per-channel count/accept; any sample matching q drops the count to 0.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    cnt_d   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (bus.d[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = bus.d[i];
          rise_d[i]  = bus.d[i];
          fall_d[i]  = ~bus.d[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.q    = level_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;

`ifdef DEBOUNCE_EDGE_STATS_EN
  logic [15:0] glitch_q, glitch_d;
  logic        abort_c;

  // One increment per edge with any abort, not per aborting channel; saturates.
  always_comb begin
    abort_c = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if ((bus.d[i] == level_q[i]) && (cnt_q[i] != '0)) begin
        abort_c = 1'b1;
      end
    end
    glitch_d = glitch_q;
    if (abort_c && (glitch_q != 16'hFFFF)) begin
      glitch_d = glitch_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign bus.glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: a WIDTH=2/STABLE_CYCLES=4 instance and a
// WIDTH=1/STABLE_CYCLES=1 instance share clock and reset. The reference model
// keeps the history of samples since reset and accepts a change when the last
// STABLE_CYCLES samples all differ from the current debounced level.
module tb_debounce_edge;

  localparam int S4 = 4;
  localparam int S1 = 1;

  logic clk;
  logic rst;

  debounce_edge_if #(.WIDTH(2)) bus4 ();
  debounce_edge_if #(.WIDTH(1)) bus1 ();

  debounce_edge #(.WIDTH(2), .STABLE_CYCLES(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  debounce_edge #(.WIDTH(1), .STABLE_CYCLES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned fails  = 0;

  // Reference model state
  logic [1:0]  mq4, er4, ef4;
  logic [1:0]  hist4[$];
  int unsigned gl4;
  logic        mq1, er1, ef1;
  logic        hist1[$];
  int unsigned gl1;

  task automatic model_reset();
    mq4 = '0; er4 = '0; ef4 = '0; gl4 = 0; hist4.delete();
    mq1 = '0; er1 = '0; ef1 = '0; gl1 = 0; hist1.delete();
  endtask

  // Called just after a clock edge with the d values that edge sampled.
  task automatic model_edge();
    int  n;
    bit  ab;
    bit  all_diff;
    hist4.push_back(bus4.d);
    n  = hist4.size();
    ab = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      er4[ch] = 1'b0;
      ef4[ch] = 1'b0;
      // A partial run existed (previous sample differed) and this sample matches q.
      if (n >= 2 && hist4[n-2][ch] != mq4[ch] && hist4[n-1][ch] == mq4[ch]) ab = 1'b1;
      all_diff = (n >= S4);
      for (int k = 0; k < S4 && k < n; k++)
        if (hist4[n-1-k][ch] == mq4[ch]) all_diff = 1'b0;
      if (all_diff) begin
        mq4[ch] = hist4[n-1][ch];
        er4[ch] = hist4[n-1][ch];
        ef4[ch] = ~hist4[n-1][ch];
      end
    end
    if (ab && gl4 < 65535) gl4++;

    hist1.push_back(bus1.d[0]);
    n  = hist1.size();
    ab = 1'b0;
    er1 = 1'b0;
    ef1 = 1'b0;
    if (n >= 2 && hist1[n-2] != mq1 && hist1[n-1] == mq1) ab = 1'b1;
    all_diff = (n >= S1);
    for (int k = 0; k < S1 && k < n; k++)
      if (hist1[n-1-k] == mq1) all_diff = 1'b0;
    if (all_diff) begin
      mq1 = hist1[n-1];
      er1 = hist1[n-1];
      ef1 = ~hist1[n-1];
    end
    if (ab && gl1 < 65535) gl1++;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q4"},    16'(bus4.q),    16'(mq4));
    check({tag, ".rise4"}, 16'(bus4.rise), 16'(er4));
    check({tag, ".fall4"}, 16'(bus4.fall), 16'(ef4));
    check({tag, ".q1"},    16'(bus1.q),    16'(mq1));
    check({tag, ".rise1"}, 16'(bus1.rise), 16'(er1));
    check({tag, ".fall1"}, 16'(bus1.fall), 16'(ef1));
`ifdef DEBOUNCE_EDGE_STATS_EN
    check({tag, ".glitch4"}, bus4.glitch_cnt, 16'(gl4));
    check({tag, ".glitch1"}, bus1.glitch_cnt, 16'(gl1));
`endif
  endtask

  // Drive inputs, take one clock edge, update the model and compare.
  task automatic step(input string tag, input logic [1:0] d4v, input logic d1v);
    bus4.d = d4v;
    bus1.d = d1v;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Assert reset between edges; outputs must clear without a clock edge.
  task automatic mid_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    rst = 1'b0;
  endtask

  logic [1:0] cur4;
  logic       t1;
  logic [7:0] bounce;

  initial begin
    rst    = 1'b1;
    bus4.d = '0;
    bus1.d = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    for (int k = 0; k < 4; k++) step("idle", 2'b00, 1'b0);

    // Clean press on channel 0
    for (int k = 0; k < 3; k++) step("press", 2'b01, 1'b0);
    check("press_early_q", 16'(bus4.q), 16'h0);
    step("press", 2'b01, 1'b0);
    check("press_q", 16'(bus4.q), 16'h1);
    check("press_rise", 16'(bus4.rise), 16'h1);
    step("press", 2'b01, 1'b0);
    check("press_rise_once", 16'(bus4.rise), 16'h0);
    for (int k = 0; k < 3; k++) step("press_hold", 2'b01, 1'b0);

    // Release
    for (int k = 0; k < 6; k++) step("release", 2'b00, 1'b0);

    // Bounce: one matching sample restarts the count
    bounce = 8'b1111_0111;
    for (int k = 0; k < 8; k++) begin
      step("bounce", {1'b0, bounce[k]}, 1'b0);
      if (k == 6) check("bounce_early_q", 16'(bus4.q), 16'h0);
    end
    check("bounce_q", 16'(bus4.q), 16'h1);
`ifdef DEBOUNCE_EDGE_STATS_EN
    check("bounce_glitch", bus4.glitch_cnt, 16'h1);
`endif
    for (int k = 0; k < 5; k++) step("bounce_rel", 2'b00, 1'b0);

    // Parallel accept on both channels
    for (int k = 0; k < 4; k++) step("parallel", 2'b11, 1'b0);
    check("parallel_rise", 16'(bus4.rise), 16'h3);
    for (int k = 0; k < 5; k++) step("parallel_rel", 2'b00, 1'b0);

    // Reset mid-count with q[1] already high
    for (int k = 0; k < 5; k++) step("pre_rst", 2'b10, 1'b1);
    for (int k = 0; k < 3; k++) step("mid_cnt", 2'b11, 1'b1);
    mid_reset("mid_rst");
    for (int k = 0; k < 3; k++) step("post_rst", 2'b11, 1'b1);
    check("post_rst_early_q", 16'(bus4.q), 16'h0);
    step("post_rst", 2'b11, 1'b1);
    check("post_rst_q", 16'(bus4.q), 16'h3);
    for (int k = 0; k < 4; k++) step("post_rst_rel", 2'b00, 1'b0);

    // STABLE_CYCLES=1 channel toggling every cycle
    t1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      t1 = ~t1;
      step("toggle", 2'b00, t1);
      check("toggle_q1", 16'(bus1.q), 16'(t1));
      check("toggle_rise1", 16'(bus1.rise), 16'(t1));
    end
`ifdef DEBOUNCE_EDGE_STATS_EN
    check("toggle_glitch1", bus1.glitch_cnt, 16'h0);
`endif

    // Randomized bouncing inputs
    cur4 = 2'b00;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) cur4[0] = ~cur4[0];
      if ($urandom_range(0, 3) == 0) cur4[1] = ~cur4[1];
      step("random", cur4, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
